// File: rtl/lclk_pkg.sv
// Shared constants, handshake state type and divider sizing helper for the line clock.
package lclk_pkg;

  localparam logic        REG_OFFSET = 1'b0;
  localparam int unsigned MON_BIT    = 7;
  localparam int unsigned IE_BIT     = 6;

  typedef enum logic {
    IDLE = 1'b0,
    VEC  = 1'b1
  } hs_state_t;

  // Never returns 0 so that an illegal DIV still yields a legal vector width.
  function automatic int unsigned div_width(input int unsigned clk, input int unsigned tick);
    int unsigned div;
    div = clk / tick;
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/lclk_debounce.sv
// Front-panel enable button: synchroniser, tick-rate shift debounce and toggle latch.
module lclk_debounce #(
  parameter int unsigned DEB_STAGES = 2,
  parameter logic        TIMER_INIT = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_button,
  output logic o_status
);

  if (DEB_STAGES < 2) begin : g_deb_chk
    $error("lclk_debounce: DEB_STAGES must be at least 2");
  end

  logic [1:0]            r_sync;
  logic [DEB_STAGES-1:0] r_shift;
  logic                  r_latch;
  logic                  r_status;

  // The latch makes a held button toggle exactly once until it is seen fully released.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync   <= '0;
      r_shift  <= '0;
      r_latch  <= 1'b0;
      r_status <= TIMER_INIT;
    end else begin
      r_sync <= {r_sync[0], i_button};
      if (i_en) begin
        r_shift <= {r_shift[DEB_STAGES-2:0], r_sync[1]};
      end
      if ((r_shift == '1) && !r_latch) begin
        r_status <= ~r_status;
        r_latch  <= 1'b1;
      end else if (r_shift == '0) begin
        r_latch <= 1'b0;
      end
    end
  end

  assign o_status = r_status;

endmodule

// File: rtl/line_clock_wb.sv
// Line-clock interrupt source: divider, debounced enable, vectored istb/iack handshake.
// Optional LCLK_SOFTREG_EN adds the Wishbone status register (MON/IE); otherwise IE is tied to 1.
module line_clock_wb
  import lclk_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned TICK_HZ    = 50,
  parameter logic [15:0] VECTOR     = 16'o000100,
  parameter int unsigned DEB_STAGES = 2,
  parameter logic        TIMER_INIT = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        irq_o,
  input  logic        istb_i,
  output logic        iack_o,
  output logic [15:0] ivec_o,
  output logic        tick_o,
  input  logic        button_i,
  output logic        timer_status
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned CNT_W = div_width(CLK_HZ, TICK_HZ);

  if (DIV < 2) begin : g_div_chk
    $error("line_clock_wb: CLK_HZ/TICK_HZ must be at least 2");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             w_raw;
  logic             w_status;

  assign w_raw = (r_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cnt <= '0;
    end else if (w_raw) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The debounce samples on the raw tick so the button can re-enable a stopped clock.
  lclk_debounce #(
    .DEB_STAGES (DEB_STAGES),
    .TIMER_INIT (TIMER_INIT)
  ) u_debounce (
    .i_clk    (wb_clk_i),
    .i_rst    (wb_rst_i),
    .i_en     (w_raw),
    .i_button (button_i),
    .o_status (w_status)
  );

  assign tick_o       = w_raw & w_status;
  assign timer_status = w_status;

  logic w_req;
  logic r_ack;

  assign w_req = wb_cyc_i & wb_stb_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= w_req;
    end
  end

  assign wb_ack_o = r_ack;

  logic        w_ie;
  logic        w_ie_clr;
  logic [15:0] w_rdata;

`ifdef LCLK_SOFTREG_EN
  logic w_wr;
  logic r_ie;
  logic r_mon;
  logic w_unused;

  assign w_wr = w_req & wb_we_i & ~r_ack & (wb_adr_i == REG_OFFSET) & wb_sel_i[0];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ie  <= 1'b0;
      r_mon <= 1'b0;
    end else begin
      if (w_wr) begin
        r_ie <= wb_dat_i[IE_BIT];
      end
      if (tick_o) begin
        r_mon <= 1'b1;
      end else if (w_wr && !wb_dat_i[MON_BIT]) begin
        r_mon <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdata          = '0;
    w_rdata[MON_BIT] = r_mon;
    w_rdata[IE_BIT]  = r_ie;
  end

  assign w_ie     = r_ie;
  assign w_ie_clr = w_wr & ~wb_dat_i[IE_BIT];
  assign w_unused = ^{wb_dat_i[15:8], wb_dat_i[5:0], wb_sel_i[1]};
`else
  logic w_unused;

  assign w_rdata  = '0;
  assign w_ie     = 1'b1;
  assign w_ie_clr = 1'b0;
  assign w_unused = ^{wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i};
`endif

  assign wb_dat_o = (r_ack && (wb_adr_i == REG_OFFSET)) ? w_rdata : '0;

  hs_state_t   r_state;
  hs_state_t   w_state_nxt;
  logic        w_take;
  logic        w_iack;
  logic [15:0] w_ivec;
  logic        r_pending;

  // A tick landing on the acknowledge cycle re-arms the request; an IE clear overrides both.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_pending <= 1'b0;
    end else if (w_ie_clr) begin
      r_pending <= 1'b0;
    end else if (tick_o && w_ie) begin
      r_pending <= 1'b1;
    end else if (w_take) begin
      r_pending <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_iack      = 1'b0;
    w_ivec      = '0;
    case (r_state)
      IDLE: begin
        if (istb_i && r_pending) begin
          w_take      = 1'b1;
          w_state_nxt = VEC;
        end
      end
      VEC: begin
        w_iack = 1'b1;
        w_ivec = VECTOR;
        if (!istb_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign irq_o  = r_pending;
  assign iack_o = w_iack;
  assign ivec_o = w_ivec;

endmodule
